// File: rtl/pipemem_pkg.sv
// Shared encodings for the pipeline memory responder: FSM states, m_rw values
// and the latency ceiling that sizes the wait counter.
package pipemem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  localparam int MAX_LATENCY = 15;

endpackage

// File: rtl/pipemem_array.sv
// Word-wide main-memory storage: synchronous write port, asynchronous read port.
// Contents are deliberately not reset so a responder reset never loses memory.
module pipemem_array #(
  parameter int AW_WORDS = 10
) (
  input  logic                clock,
  input  logic                we,
  input  logic [AW_WORDS-1:0] waddr,
  input  logic [31:0]         wdata,
  input  logic [AW_WORDS-1:0] raddr,
  output logic [31:0]         rdata
);

  logic [31:0] r_mem [0:(1<<AW_WORDS)-1];

  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/pipemem_responder.sv
// Fixed-latency memory responder for the cache m_* handshake. Requests are
// captured on acceptance, restarted on redirect, and completed with a 1-cycle m_ready.
module pipemem_responder
  import pipemem_pkg::*;
#(
  parameter int AW_WORDS = 10,
  parameter int LATENCY  = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] m_a,
  input  logic        m_strobe,
  input  logic        m_rw,
  input  logic [31:0] m_din,
  output logic [31:0] m_dout,
  output logic        m_ready
);

  localparam int CW = $clog2(MAX_LATENCY + 1);
  localparam logic [CW-1:0] RESTART_COUNT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  state_t              r_state;
  state_t              w_nextState;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       w_nextCount;
  logic [AW_WORDS-1:0] r_idx;
  logic [AW_WORDS-1:0] w_nextIdx;
  logic [AW_WORDS-1:0] w_reqIdx;
  logic                r_rw;
  logic                w_nextRw;
  logic [31:0]         r_din;
  logic [31:0]         w_nextDin;
  logic                r_ready;
  logic [31:0]         r_dout;
  logic                w_enterDone;
  logic                w_we;
  logic [31:0]         w_rdata;
  logic                w_unusedAddrBits;

  assign w_reqIdx         = m_a[AW_WORDS+1:2];
  assign w_unusedAddrBits = ^{m_a[31:AW_WORDS+2], m_a[1:0]};

  // The w_next* capture values double as the transaction being completed, so an
  // IDLE->DONE hop (LATENCY=1) uses the live inputs rather than stale registers.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_nextIdx   = r_idx;
    w_nextRw    = r_rw;
    w_nextDin   = r_din;
    case (r_state)
      ST_IDLE: begin
        if (m_strobe) begin
          w_nextIdx = w_reqIdx;
          w_nextRw  = m_rw;
          w_nextDin = m_din;
          if (LATENCY == 1) begin
            w_nextState = ST_DONE;
          end else begin
            w_nextState = ST_BUSY;
            w_nextCount = RESTART_COUNT;
          end
        end
      end
      ST_BUSY: begin
        if (!m_strobe) begin
          w_nextState = ST_IDLE;
        end else if ((w_reqIdx != r_idx) || (m_rw != r_rw)) begin
          w_nextIdx   = w_reqIdx;
          w_nextRw    = m_rw;
          w_nextDin   = m_din;
          w_nextCount = RESTART_COUNT;
        end else if (r_count == '0) begin
          w_nextState = ST_DONE;
        end else begin
          w_nextCount = r_count - 1'b1;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  assign w_enterDone = (w_nextState == ST_DONE) && (r_state != ST_DONE);
  assign w_we        = w_enterDone && (w_nextRw == MEM_WR) && resetn;

  pipemem_array #(
    .AW_WORDS (AW_WORDS)
  ) u_array (
    .clock (clock),
    .we    (w_we),
    .waddr (w_nextIdx),
    .wdata (w_nextDin),
    .raddr (w_nextIdx),
    .rdata (w_rdata)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_idx   <= '0;
      r_rw    <= MEM_RD;
      r_din   <= '0;
      r_ready <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      r_idx   <= w_nextIdx;
      r_rw    <= w_nextRw;
      r_din   <= w_nextDin;
      r_ready <= w_enterDone;
      if (w_enterDone) begin
        r_dout <= (w_nextRw == MEM_RD) ? w_rdata : w_nextDin;
      end
    end
  end

  assign m_ready = r_ready;
  assign m_dout  = r_dout;

endmodule

// File: tb/tb_pipemem_responder.sv
// Bench for pipemem_responder: a LATENCY=4 and a LATENCY=1 instance share the
// request bus; each is checked against its own word-array model.
module tb_pipemem_responder;

  logic        clock;
  logic        resetn;
  logic [31:0] m_a;
  logic        m_rw;
  logic [31:0] m_din;
  logic        mStrobe [2];
  logic        mReady  [2];
  logic [31:0] mDout   [2];

  logic [31:0] modelMem [2][1024];
  int          checkCount;
  int          passCount;

  pipemem_responder #(.AW_WORDS(10), .LATENCY(4)) dut4 (
    .clock    (clock),
    .resetn   (resetn),
    .m_a      (m_a),
    .m_strobe (mStrobe[0]),
    .m_rw     (m_rw),
    .m_din    (m_din),
    .m_dout   (mDout[0]),
    .m_ready  (mReady[0])
  );

  pipemem_responder #(.AW_WORDS(10), .LATENCY(1)) dut1 (
    .clock    (clock),
    .resetn   (resetn),
    .m_a      (m_a),
    .m_strobe (mStrobe[1]),
    .m_rw     (m_rw),
    .m_din    (m_din),
    .m_dout   (mDout[1]),
    .m_ready  (mReady[1])
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // One request, starting at the current negedge. mode 0 = plain, 1 = drop strobe in
  // cycle 'at', 2 = redirect to request B in cycle 'at'. Ready is due LATENCY cycles
  // after the latest (re)start; the read data comes from the model array.
  task automatic applyStimulus(input int sel, input logic [31:0] addrA, input logic rwA,
                               input logic [31:0] dinA, input int mode, input int at,
                               input logic [31:0] addrB, input logic rwB, input logic [31:0] dinB);
    int          lat;
    int          start;
    int          abortEnd;
    logic        aborted;
    logic        done;
    logic [31:0] curA;
    logic        curRw;
    logic [31:0] curD;
    logic [31:0] expData;
    lat      = (sel == 0) ? 4 : 1;
    m_a      = addrA;
    m_rw     = rwA;
    m_din    = dinA;
    mStrobe[sel] = 1'b1;
    curA     = addrA;
    curRw    = rwA;
    curD     = dinA;
    start    = 0;
    abortEnd = 0;
    aborted  = 1'b0;
    done     = 1'b0;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge clock);
      if (!aborted && n == start + lat) begin
        checkOutput("ready", 32'(mReady[sel]), 32'd1);
        expData = curRw ? curD : modelMem[sel][curA[11:2]];
        checkOutput("data", mDout[sel], expData);
        if (curRw) modelMem[sel][curA[11:2]] = curD;
        mStrobe[sel] = 1'b0;
        @(negedge clock);
        checkOutput("readyPulse", 32'(mReady[sel]), 32'd0);
        checkOutput("doutHold", mDout[sel], expData);
        done = 1'b1;
      end else begin
        checkOutput("readyIdle", 32'(mReady[sel]), 32'd0);
        if (aborted && n >= abortEnd) begin
          done = 1'b1;
        end else if (mode == 1 && n == at) begin
          mStrobe[sel] = 1'b0;
          aborted  = 1'b1;
          abortEnd = n + lat + 1;
        end else if (mode == 2 && n == at) begin
          m_a   = addrB;
          m_rw  = rwB;
          m_din = dinB;
          curA  = addrB;
          curRw = rwB;
          curD  = dinB;
          start = n;
        end
      end
    end
    if (!done) checkOutput("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          sel;
    int          idx;
    int          mode;
    clock      = 1'b0;
    resetn     = 1'b0;
    m_a        = '0;
    m_rw       = 1'b0;
    m_din      = '0;
    mStrobe[0] = 1'b0;
    mStrobe[1] = 1'b0;
    checkCount = 0;
    passCount  = 0;
    for (int s = 0; s < 2; s++) for (int w = 0; w < 1024; w++) modelMem[s][w] = '0;

    #1;
    checkOutput("rstReady4", 32'(mReady[0]), 32'd0);
    checkOutput("rstDout4", mDout[0], 32'd0);
    checkOutput("rstReady1", 32'(mReady[1]), 32'd0);
    checkOutput("rstDout1", mDout[1], 32'd0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // preload and basic read latency
    applyStimulus(0, 32'h100, 1'b1, 32'h8C220004, 0, 0, 0, 0, 0);
    applyStimulus(0, 32'h100, 1'b0, 32'h0, 0, 0, 0, 0, 0);

    // write then immediate read, plus alias
    applyStimulus(0, 32'h204, 1'b1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    applyStimulus(0, 32'h204, 1'b0, 32'h0, 0, 0, 0, 0, 0);
    applyStimulus(0, 32'h1204, 1'b0, 32'h0, 0, 0, 0, 0, 0);
    applyStimulus(0, 32'h207, 1'b0, 32'h0, 0, 0, 0, 0, 0);

    // aborted read and aborted write leave memory alone
    applyStimulus(0, 32'h100, 1'b0, 32'h0, 1, 2, 0, 0, 0);
    applyStimulus(0, 32'h100, 1'b1, 32'h12345678, 1, 2, 0, 0, 0);
    applyStimulus(0, 32'h100, 1'b0, 32'h0, 0, 0, 0, 0, 0);

    // redirect while stalled
    applyStimulus(0, 32'h104, 1'b1, 32'hA5A50041, 0, 0, 0, 0, 0);
    applyStimulus(0, 32'h100, 1'b0, 32'h0, 2, 2, 32'h104, 1'b0, 32'h0);

    // reset in the middle of a write
    applyStimulus(0, 32'h300, 1'b1, 32'hC0C00300, 0, 0, 0, 0, 0);
    m_a        = 32'h300;
    m_rw       = 1'b1;
    m_din      = 32'hBAD0BAD0;
    mStrobe[0] = 1'b1;
    @(negedge clock);
    checkOutput("rstWrBusy", 32'(mReady[0]), 32'd0);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    checkOutput("asyncReady", 32'(mReady[0]), 32'd0);
    checkOutput("asyncDout", mDout[0], 32'd0);
    mStrobe[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    applyStimulus(0, 32'h300, 1'b0, 32'h0, 0, 0, 0, 0, 0);

    // LATENCY=1 back-to-back reads with strobe held
    applyStimulus(1, 32'h0, 1'b1, 32'h11110000, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h4, 1'b1, 32'h22220004, 0, 0, 0, 0, 0);
    m_a        = 32'h0;
    m_rw       = 1'b0;
    mStrobe[1] = 1'b1;
    @(negedge clock);
    checkOutput("b2bReady0", 32'(mReady[1]), 32'd1);
    checkOutput("b2bData0", mDout[1], modelMem[1][0]);
    m_a = 32'h4;
    @(negedge clock);
    checkOutput("b2bGap", 32'(mReady[1]), 32'd0);
    @(negedge clock);
    checkOutput("b2bReady1", 32'(mReady[1]), 32'd1);
    checkOutput("b2bData1", mDout[1], modelMem[1][1]);
    mStrobe[1] = 1'b0;
    @(negedge clock);
    checkOutput("b2bEnd", 32'(mReady[1]), 32'd0);

    // randomized traffic over a small aliased window
    for (int i = 0; i < 80; i++) begin
      sel  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      idx  = $urandom_range(0, 7);
      a    = $urandom;
      a[11:2] = 10'(idx);
      b    = $urandom;
      b[11:2] = 10'((idx + 1) % 8);
      mode = (sel == 1) ? 0 : $urandom_range(0, 2);
      applyStimulus(sel, a, 1'($urandom_range(0, 1)), $urandom, mode, $urandom_range(1, 3),
                    b, 1'($urandom_range(0, 1)), $urandom);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
